ifu_fetch_queue: RTL and testbench

Instruction fetch unit for the pipelined MIPS core. It sits directly downstream of the next-PC logic: it takes a reset PC plus branch/jump redirects, issues word fetches to instruction memory over a request/grant/response handshake, and buffers the returned {pc, instruction} pairs in a small in-order queue. Decode drains the queue through a valid/ready interface. A redirect flushes the queue and discards any in-flight response.

---
 rtl/ifu_fetch_queue_if.sv | 26 ++
 rtl/ifu_fetch_queue.sv | 120 ++++++++++++
 tb/tb_ifu_fetch_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue signal bundle: redirect input, instruction-memory handshake,
// decode-side valid/ready output and the sticky protocol error flag.
interface ifu_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_word;
    logic        protocol_err;

    modport slave (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_pc, inst_word, protocol_err
    );

    modport master (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_pc, inst_word, protocol_err
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: one outstanding imem request, in-order {pc, word}
// queue to decode, redirect flush with epoch-based drop of in-flight responses.
module ifu_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic              clk,
    input logic              reset,
    ifu_fetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL  = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CONE  = 1;
    localparam logic [PW-1:0] PONE  = 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          epoch_q, epoch_d;
    logic [31:0]   pending_pc_q, pending_pc_d;
    logic          pending_epoch_q, pending_epoch_d;
    logic          perr_q, perr_d;
    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_word_q [DEPTH];

    logic issue, grant, enq, deq;

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        count_d         = count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        epoch_d         = epoch_q;
        pending_pc_d    = pending_pc_q;
        pending_epoch_d = pending_epoch_q;
        perr_d          = perr_q;

        // Request is masked while reset is held so nothing is granted before the
        // first post-reset cycle.
        issue = reset && (state_q == IDLE) && (count_q < FULL) && !bus.redirect_valid;
        grant = issue && bus.imem_gnt;
        enq   = bus.imem_rvalid && (state_q == WAIT) && (pending_epoch_q == epoch_q)
                && !bus.redirect_valid;
        deq   = (count_q != '0) && bus.inst_ready && !bus.redirect_valid;

        if (bus.imem_rvalid && state_q == IDLE)
            perr_d = 1'b1;

        if (bus.redirect_valid) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            epoch_d    = ~epoch_q;
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            // A response landing in the redirect cycle retires the outstanding request.
            if (state_q != IDLE)
                state_d = bus.imem_rvalid ? IDLE : DRAIN;
        end else begin
            if (grant) begin
                pending_pc_d    = fetch_pc_q;
                pending_epoch_d = epoch_q;
                fetch_pc_d      = fetch_pc_q + 32'd4;
                state_d         = WAIT;
            end
            if (bus.imem_rvalid && state_q != IDLE)
                state_d = IDLE;
            if (enq)
                tail_d = tail_q + PONE;
            if (deq)
                head_d = head_q + PONE;
            case ({enq, deq})
                2'b10:   count_d = count_q + CONE;
                2'b01:   count_d = count_q - CONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RESET_PC;
            count_q         <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            epoch_q         <= 1'b0;
            pending_pc_q    <= '0;
            pending_epoch_q <= 1'b0;
            perr_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            count_q         <= count_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            epoch_q         <= epoch_d;
            pending_pc_q    <= pending_pc_d;
            pending_epoch_q <= pending_epoch_d;
            perr_q          <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc_q[tail_q]   <= pending_pc_q;
            mem_word_q[tail_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = fetch_pc_q;
    assign bus.inst_valid   = (count_q != '0);
    assign bus.inst_pc      = bus.inst_valid ? mem_pc_q[head_q]   : '0;
    assign bus.inst_word    = bus.inst_valid ? mem_word_q[head_q] : '0;
    assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with a {pc, word} scoreboard filled when
// responses are driven and drained when decode accepts an entry.
module tb_ifu_fetch_queue;
    logic clk;
    logic reset;
    int unsigned errors;
    int unsigned checks;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;
    ent_t sb[$];

    ifu_fetch_queue_if bus();

    ifu_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks head validity against the scoreboard, pops on accept, then advances one cycle.
    task automatic clk_step();
        ent_t e;
        if (reset && !bus.redirect_valid) begin
            chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, sb.size() != 0});
            if (bus.inst_valid && bus.inst_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("inst_pc", bus.inst_pc, e.pc);
                chk("inst_word", bus.inst_word, e.word);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic grant_only(input logic [31:0] addr);
        bus.imem_gnt = 1'b1;
        #1;
        chk("req", {31'b0, bus.imem_req}, 32'd1);
        chk("addr", bus.imem_addr, addr);
        clk_step();
        bus.imem_gnt = 1'b0;
    endtask

    task automatic fetch_resp(input logic [31:0] addr);
        grant_only(addr);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = wd(addr);
        #1;
        chk("req_wait", {31'b0, bus.imem_req}, 32'd0);
        clk_step();
        bus.imem_rvalid = 1'b0;
        sb.push_back('{pc: addr, word: wd(addr)});
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.inst_ready     = 1'b0;
        clk_step();
        clk_step();
        sb.delete();
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_perr", {31'b0, bus.protocol_err}, 32'd0);
        chk("rst_pc", bus.inst_pc, 32'd0);
        chk("rst_word", bus.inst_word, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Streaming at minimum latency, decode always ready
        do_reset();
        bus.inst_ready = 1'b1;
        fetch_resp(32'h3000);
        fetch_resp(32'h3004);
        fetch_resp(32'h3008);
        #1;
        clk_step();
        chk("perr_stream", {31'b0, bus.protocol_err}, 32'd0);

        // Fill to DEPTH with decode stalled, then release a single entry
        do_reset();
        fetch_resp(32'h3000);
        fetch_resp(32'h3004);
        fetch_resp(32'h3008);
        fetch_resp(32'h300C);
        #1;
        chk("full_req0", {31'b0, bus.imem_req}, 32'd0);
        clk_step();
        chk("full_req1", {31'b0, bus.imem_req}, 32'd0);
        bus.inst_ready = 1'b1;
        clk_step();
        bus.inst_ready = 1'b0;
        #1;
        chk("resume_req", {31'b0, bus.imem_req}, 32'd1);
        chk("resume_addr", bus.imem_addr, 32'h3010);
        fetch_resp(32'h3010);
        bus.inst_ready = 1'b1;
        repeat (5) clk_step();

        // Redirect while a granted request is in flight; stale response dropped
        do_reset();
        bus.inst_ready = 1'b1;
        fetch_resp(32'h3000);
        fetch_resp(32'h3004);
        grant_only(32'h3008);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_4003;
        #1;
        chk("redir_req", {31'b0, bus.imem_req}, 32'd0);
        clk_step();
        sb.delete();
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = wd(32'h3008);
        #1;
        chk("drain_req", {31'b0, bus.imem_req}, 32'd0);
        clk_step();
        bus.imem_rvalid = 1'b0;
        fetch_resp(32'h4000);
        #1;
        clk_step();
        chk("perr_redir", {31'b0, bus.protocol_err}, 32'd0);

        // Redirect coincident with a response and a dequeue, two entries queued
        do_reset();
        fetch_resp(32'h3000);
        fetch_resp(32'h3004);
        grant_only(32'h3008);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_5000;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = wd(32'h3008);
        bus.inst_ready     = 1'b1;
        #1;
        clk_step();
        sb.delete();
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid    = 1'b0;
        #1;
        chk("coinc_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("coinc_addr", bus.imem_addr, 32'h5000);
        fetch_resp(32'h5000);
        #1;
        clk_step();

        // Spurious response while idle: sticky error, queue untouched
        do_reset();
        fetch_resp(32'h3000);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        #1;
        clk_step();
        bus.imem_rvalid = 1'b0;
        #1;
        chk("perr_set", {31'b0, bus.protocol_err}, 32'd1);
        chk("perr_pc", bus.inst_pc, 32'h3000);
        chk("perr_hold_addr", bus.imem_addr, 32'h3004);
        repeat (3) clk_step();
        chk("perr_sticky", {31'b0, bus.protocol_err}, 32'd1);
        bus.inst_ready = 1'b1;
        clk_step();
        bus.inst_ready = 1'b0;

        // Reset mid-WAIT with three entries queued
        do_reset();
        fetch_resp(32'h3000);
        fetch_resp(32'h3004);
        fetch_resp(32'h3008);
        grant_only(32'h300C);
        reset = 1'b0;
        #1;
        chk("rstw_req_now", {31'b0, bus.imem_req}, 32'd0);
        clk_step();
        sb.delete();
        chk("rstw_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rstw_req", {31'b0, bus.imem_req}, 32'd0);
        reset           = 1'b1;
        bus.imem_rvalid = 1'b1;
        #1;
        clk_step();
        bus.imem_rvalid = 1'b0;
        #1;
        chk("rstw_perr", {31'b0, bus.protocol_err}, 32'd1);
        chk("rstw_addr", bus.imem_addr, 32'h3000);
        bus.inst_ready = 1'b1;
        fetch_resp(32'h3000);
        #1;
        clk_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
